// File: rtl/uart_port_ctrl.sv
// uart_port_ctrl: sequencing controller between the CPU port_out/port_in
// register pair and a byte UART. The CPU issues commands on rising edges of
// port_out bits, the block queues bytes in small FIFOs, runs the UART
// handshakes itself and reports status on port_in.
//
// Ports:
//   clk, rst       block clock, asynchronous active-high reset
//   port_out[7:0]  byte to transmit
//   port_out[8]    rise: push byte into TX FIFO (dropped + tx_drop when full)
//   port_out[9]    rise: pop RX FIFO head
//   port_out[10]   rise: clear rx_ovf and tx_drop
//   port_out[11]   loopback select (only with UART_CTRL_LOOPBACK_EN)
//   port_in        {18'b0, loopback, tx_drop, rx_ovf, tx_idle, tx_full,
//                   rx_valid, rx_head[7:0]}
//   uart_din/uart_wr_en/uart_tx_busy   UART transmit side
//   uart_dout/uart_rdy/uart_rdy_clr    UART receive side
//
// Build option: define UART_CTRL_LOOPBACK_EN to route popped TX bytes
// straight into the RX FIFO while port_out[11] is set.

module uart_port_ctrl #(
    parameter int TX_DEPTH     = 4,
    parameter int RX_DEPTH     = 4,
    parameter int BUSY_TIMEOUT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] port_out,
    output logic [31:0] port_in,
    output logic [7:0]  uart_din,
    output logic        uart_wr_en,
    input  logic        uart_tx_busy,
    input  logic [7:0]  uart_dout,
    input  logic        uart_rdy,
    output logic        uart_rdy_clr
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        T_IDLE,
        T_WAIT_BUSY,
        T_WAIT_DONE
    } tx_state_t;

    typedef enum logic {
        R_IDLE,
        R_CLR
    } rx_state_t;

    tx_state_t tx_state;
    rx_state_t rx_state;

    logic [2:0]       prev;
    logic             cmd_push, cmd_pop, cmd_clr;
    logic             loopback;
    logic             unused_bits;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW:0]   tx_wptr, tx_rptr;
    logic             tx_empty, tx_full;
    logic [7:0]       tx_head;
    logic             tx_push, tx_pop, tx_drop_set;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW:0]   rx_wptr, rx_rptr;
    logic             rx_empty, rx_full;
    logic [7:0]       rx_head;
    logic             rx_push_req, rx_push, rx_pop, rx_ovf_set;
    logic [7:0]       rx_push_data;
    logic             uart_push;

    logic             rx_ovf, tx_drop;
    logic [TMR_W-1:0] tmr;

`ifdef UART_CTRL_LOOPBACK_EN
    assign loopback    = port_out[11];
    assign unused_bits = ^port_out[31:12];
`else
    assign loopback    = 1'b0;
    assign unused_bits = ^port_out[31:11];
`endif

    // Command edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= port_out[10:8];
        end
    end

    assign cmd_push = port_out[8]  & ~prev[0];
    assign cmd_pop  = port_out[9]  & ~prev[1];
    assign cmd_clr  = port_out[10] & ~prev[2];

    // FIFO status: pointers carry one extra wrap bit
    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                      (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
    assign tx_head  = tx_mem[tx_rptr[TX_AW-1:0]];

    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                      (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
    assign rx_head  = rx_mem[rx_rptr[RX_AW-1:0]];

    // A pop in the same cycle frees a slot, so a push at full still lands
    assign tx_pop      = (tx_state == T_IDLE) && !tx_empty && (loopback || !uart_tx_busy);
    assign tx_push     = cmd_push && (!tx_full || tx_pop);
    assign tx_drop_set = cmd_push && tx_full && !tx_pop;

    assign uart_push = !loopback && (rx_state == R_IDLE) && uart_rdy;

`ifdef UART_CTRL_LOOPBACK_EN
    assign rx_push_req  = uart_push || (loopback && tx_pop);
    assign rx_push_data = loopback ? tx_head : uart_dout;
`else
    assign rx_push_req  = uart_push;
    assign rx_push_data = uart_dout;
`endif

    assign rx_pop     = cmd_pop && !rx_empty;
    assign rx_push    = rx_push_req && (!rx_full || rx_pop);
    assign rx_ovf_set = rx_push_req && rx_full && !rx_pop;

    // FIFO storage (contents are don't-care while pointers say empty)
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr[TX_AW-1:0]] <= port_out[7:0];
        end
        if (rx_push) begin
            rx_mem[rx_wptr[RX_AW-1:0]] <= rx_push_data;
        end
    end

    // Pointers and sticky flags; a set in the same cycle beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_ovf  <= 1'b0;
            tx_drop <= 1'b0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;

            if (tx_drop_set)  tx_drop <= 1'b1;
            else if (cmd_clr) tx_drop <= 1'b0;

            if (rx_ovf_set)   rx_ovf <= 1'b1;
            else if (cmd_clr) rx_ovf <= 1'b0;
        end
    end

    // TX FSM: one wr_en strobe per byte, then track the UART busy window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= T_IDLE;
            tmr        <= '0;
            uart_wr_en <= 1'b0;
            uart_din   <= '0;
        end else begin
            uart_wr_en <= 1'b0;
            case (tx_state)
                T_IDLE: begin
                    if (tx_pop && !loopback) begin
                        uart_din   <= tx_head;
                        uart_wr_en <= 1'b1;
                        tmr        <= '0;
                        tx_state   <= T_WAIT_BUSY;
                    end
                end
                T_WAIT_BUSY: begin
                    // Give up waiting for busy after BUSY_TIMEOUT cycles
                    if (uart_tx_busy) begin
                        tx_state <= T_WAIT_DONE;
                    end else if (tmr == TMR_W'(BUSY_TIMEOUT - 1)) begin
                        tx_state <= T_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                T_WAIT_DONE: begin
                    if (!uart_tx_busy) tx_state <= T_IDLE;
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // RX FSM: capture once, pulse rdy_clr, wait for rdy to drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= R_IDLE;
            uart_rdy_clr <= 1'b0;
        end else begin
            uart_rdy_clr <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (uart_push) begin
                        uart_rdy_clr <= 1'b1;
                        rx_state     <= R_CLR;
                    end
                end
                R_CLR: begin
                    if (!uart_rdy) rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Status word
    always_comb begin
        port_in       = '0;
        port_in[7:0]  = rx_empty ? 8'h00 : rx_head;
        port_in[8]    = !rx_empty;
        port_in[9]    = tx_full;
        port_in[10]   = tx_empty && (tx_state == T_IDLE);
        port_in[11]   = rx_ovf;
        port_in[12]   = tx_drop;
        port_in[13]   = loopback;
    end

endmodule

// File: tb/tb_uart_port_ctrl.sv
// tb_uart_port_ctrl: self-checking bench for uart_port_ctrl with a behavioural
// UART transmitter (busy window after each wr_en) and receiver driver.
// Transmitted bytes are checked against a TX scoreboard queue as wr_en fires;
// received bytes against an RX queue as the CPU reads them back.

module tb_uart_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] port_out;
    logic [31:0] port_in;
    logic [7:0]  uart_din;
    logic        uart_wr_en;
    logic        uart_tx_busy;
    logic [7:0]  uart_dout;
    logic        uart_rdy;
    logic        uart_rdy_clr;

    always #5 clk = ~clk;

    uart_port_ctrl #(
        .TX_DEPTH(4),
        .RX_DEPTH(4),
        .BUSY_TIMEOUT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .port_out(port_out),
        .port_in(port_in),
        .uart_din(uart_din),
        .uart_wr_en(uart_wr_en),
        .uart_tx_busy(uart_tx_busy),
        .uart_dout(uart_dout),
        .uart_rdy(uart_rdy),
        .uart_rdy_clr(uart_rdy_clr)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    int wr_count  = 0;
    int clr_count = 0;
    bit prev_wr   = 1'b0;
    bit prev_clr  = 1'b0;

    bit force_busy = 1'b0;
    int busy_len   = 10;
    bit pend       = 1'b0;
    int left       = 0;

    int base, n, lat;

    typedef struct {
        bit          is_rx;
        logic [7:0]  data;
        int          busy_len;
        int          lat;
        logic [31:0] status;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // UART transmitter model: busy rises the cycle after wr_en, lasts busy_len
    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (force_busy) begin
                uart_tx_busy = 1'b1;
                pend = 1'b0;
                left = 0;
            end else if (pend) begin
                pend = 1'b0;
                if (busy_len > 0) begin
                    uart_tx_busy = 1'b1;
                    left = busy_len - 1;
                end else begin
                    uart_tx_busy = 1'b0;
                end
            end else if (left > 0) begin
                uart_tx_busy = 1'b1;
                left--;
            end else begin
                uart_tx_busy = 1'b0;
            end
            if (uart_wr_en && !force_busy) pend = 1'b1;
        end
    end

    // Output monitors: TX scoreboard pop and strobe width checks
    always @(negedge clk) begin
        if (uart_wr_en) begin
            wr_count++;
            check("wr_en_width", 32'(prev_wr), 32'h0);
            if (tx_q.size() == 0) check("wr_en_spurious", 32'(uart_wr_en), 32'h0);
            else check("tx_byte", 32'(uart_din), 32'(tx_q.pop_front()));
        end
        prev_wr = uart_wr_en;
        if (uart_rdy_clr) begin
            clr_count++;
            check("rdy_clr_width", 32'(prev_clr), 32'h0);
        end
        prev_clr = uart_rdy_clr;
    end

    task automatic pulse_bit(input int b);
        port_out[b] = 1'b1;
        @(negedge clk);
        port_out[b] = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b, input bit ok);
        port_out[7:0] = b;
        if (ok) tx_q.push_back(b);
        pulse_bit(8);
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit ok, input bit with_pop);
        int k = 0;
        uart_dout = b;
        uart_rdy  = 1'b1;
        if (with_pop) port_out[9] = 1'b1;
        if (ok) rx_q.push_back(b);
        do begin
            @(negedge clk);
            k++;
        end while (!uart_rdy_clr && k < 10);
        check("rx_clr_seen", 32'(uart_rdy_clr), 32'h1);
        uart_rdy    = 1'b0;
        port_out[9] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 8'h41, 10, 12, 32'h0000_0400};
        vecs[1] = '{1'b1, 8'h5A, 0,  0,  32'h0000_055A};
        vecs[2] = '{1'b0, 8'hA5, 2,  4,  32'h0000_0400};
        vecs[3] = '{1'b0, 8'h00, 0,  3,  32'h0000_0400};
        vecs[4] = '{1'b1, 8'h00, 0,  0,  32'h0000_0500};
        vecs[5] = '{1'b0, 8'hFF, 1,  3,  32'h0000_0400};
        vecs[6] = '{1'b1, 8'hFF, 0,  0,  32'h0000_05FF};
        vecs[7] = '{1'b0, 8'h3C, 4,  6,  32'h0000_0400};

        rst       = 1'b1;
        port_out  = '0;
        uart_dout = '0;
        uart_rdy  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_port_in", port_in, 32'h0000_0400);
        check("reset_wr_en", 32'(uart_wr_en), 32'h0);
        check("reset_rdy_clr", 32'(uart_rdy_clr), 32'h0);
        check("reset_din", 32'(uart_din), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_port_in", port_in, 32'h0000_0400);

        // Single-byte transfers in both directions
        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].is_rx) begin
                busy_len = vecs[i].busy_len;
                base = wr_count;
                push_tx(vecs[i].data, 1'b1);
                n = 0;
                while (!uart_wr_en && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("tx_strobe_seen", 32'(uart_wr_en), 32'h1);
                lat = 0;
                while (!port_in[10] && lat < 50) begin
                    @(negedge clk);
                    lat++;
                end
                check("tx_idle_latency", 32'(lat), 32'(vecs[i].lat));
                check("tx_status", port_in, vecs[i].status);
                check("tx_pulses", 32'(wr_count - base), 32'h1);
            end else begin
                base = clr_count;
                rx_byte(vecs[i].data, 1'b1, 1'b0);
                check("rx_clr_pulses", 32'(clr_count - base), 32'h1);
                check("rx_status", port_in, vecs[i].status);
                check("rx_head", 32'(port_in[7:0]), 32'(rx_q.pop_front()));
                pulse_bit(9);
                check("rx_after_pop", port_in, 32'h0000_0400);
            end
        end

        // TX FIFO fill against a stuck-busy UART, drop on the fifth byte
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        base = wr_count;
        for (int i = 0; i < 5; i++) begin
            push_tx(8'h10 + 8'(i), i < 4);
            if (i == 3) check("tx_full_at_4", port_in, 32'h0000_0200);
        end
        check("tx_drop_set", port_in, 32'h0000_1200);
        busy_len   = 2;
        force_busy = 1'b0;
        n = 0;
        while ((wr_count - base < 4 || !port_in[10]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_drain_pulses", 32'(wr_count - base), 32'h4);
        check("tx_q_empty", 32'(tx_q.size()), 32'h0);
        check("tx_drain_status", port_in, 32'h0000_1400);
        pulse_bit(10);
        check("tx_drop_clear", port_in, 32'h0000_0400);

        // RX overflow, then simultaneous pop and capture at full
        base = clr_count;
        for (int i = 0; i < 5; i++) rx_byte(8'h20 + 8'(i), i < 4, 1'b0);
        check("rx_ovf_pulses", 32'(clr_count - base), 32'h5);
        check("rx_ovf_status", port_in, 32'h0000_0D20);
        pulse_bit(10);
        check("rx_ovf_clear", port_in, 32'h0000_0520);
        void'(rx_q.pop_front());
        rx_byte(8'h25, 1'b1, 1'b1);
        check("rx_simul_status", port_in, 32'h0000_0521);
        for (int i = 0; i < 4; i++) begin
            check("rx_drain_head", port_in, 32'h0000_0500 | 32'(rx_q.pop_front()));
            pulse_bit(9);
        end
        check("rx_drained", port_in, 32'h0000_0400);

        // Reset while waiting for busy to fall with two bytes queued
        busy_len = 10;
        base = wr_count;
        push_tx(8'h61, 1'b1);
        push_tx(8'h62, 1'b1);
        push_tx(8'h63, 1'b1);
        check("pre_reset_status", port_in, 32'h0000_0000);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_status", port_in, 32'h0000_0400);
        rst = 1'b0;
        tx_q.delete();
        repeat (20) @(negedge clk);
        check("no_reissue", 32'(wr_count - base), 32'h1);
        check("post_reset_status", port_in, 32'h0000_0400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
